// File: rtl/sc1_prog_loader.sv
// Boot loader: packs a framed byte stream (SYNC, LEN, LEN*4 bytes, little-endian) into program RAM writes and sequences sc1_cpu reset.
// Write strobe lands one cycle after each word's 4th byte; in_ready drops only in HOLD, on the final write cycle and on the timeout cycle.
module sc1_prog_loader #(
    parameter int          ROM_ADDR_WIDTH = 8,
    parameter int          HOLD_CYCLES    = 4,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      prog_we,
    output logic [ROM_ADDR_WIDTH-1:0] prog_addr,
    output logic [31:0]               prog_data,
    output logic                      cpu_reset,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);

    localparam int HW = $clog2(HOLD_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HOLD,
        S_IDLE,
        S_LEN,
        S_DATA
    } state_t;

    state_t                    state;
    logic [HW-1:0]             hold_cnt;
    logic [TW-1:0]             to_cnt;
    logic [8:0]                words_left;
    logic [1:0]                byte_idx;
    logic [23:0]               word_buf;
    logic [ROM_ADDR_WIDTH-1:0] word_addr;
    logic                      last_wr;
    logic                      from_load;

    logic in_frame;
    logic timeout_hit;
    logic xfer;

    // The last idle cycle of the timeout window refuses bytes, so the abort never races a transfer.
    assign in_frame    = (state == S_LEN) || (state == S_DATA);
    assign timeout_hit = in_frame && !last_wr && (to_cnt == TO_LAST);
    assign in_ready    = (state != S_HOLD) && !last_wr && !timeout_hit;
    assign xfer        = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_HOLD;
            hold_cnt   <= '0;
            to_cnt     <= '0;
            words_left <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
            word_addr  <= '0;
            last_wr    <= 1'b0;
            from_load  <= 1'b0;
            cpu_reset  <= 1'b1;
            prog_we    <= 1'b0;
            prog_addr  <= '0;
            prog_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            prog_we <= 1'b0;
            done    <= 1'b0;
            case (state)
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state     <= S_IDLE;
                        hold_cnt  <= '0;
                        cpu_reset <= 1'b0;
                        done      <= from_load;
                        from_load <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (xfer && (in_data == SYNC_BYTE)) begin
                        state     <= S_LEN;
                        cpu_reset <= 1'b1;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                        to_cnt    <= '0;
                    end
                end
                S_LEN: begin
                    if (xfer) begin
                        words_left <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                        word_addr  <= '0;
                        byte_idx   <= '0;
                        to_cnt     <= '0;
                        state      <= S_DATA;
                    end else if (timeout_hit) begin
                        state <= S_IDLE;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (last_wr) begin
                        // Final write strobe is on the bus this cycle; CPU stays in reset through HOLD.
                        state     <= S_HOLD;
                        hold_cnt  <= '0;
                        busy      <= 1'b0;
                        last_wr   <= 1'b0;
                        from_load <= 1'b1;
                    end else if (xfer) begin
                        to_cnt   <= '0;
                        byte_idx <= byte_idx + 1'b1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= in_data;
                            2'd1: word_buf[15:8]  <= in_data;
                            2'd2: word_buf[23:16] <= in_data;
                            default: begin
                                prog_we    <= 1'b1;
                                prog_data  <= {in_data, word_buf};
                                prog_addr  <= word_addr;
                                word_addr  <= word_addr + 1'b1;
                                words_left <= words_left - 1'b1;
                                if (words_left == 9'd1) begin
                                    last_wr <= 1'b1;
                                end
                            end
                        endcase
                    end else if (timeout_hit) begin
                        state <= S_IDLE;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= S_HOLD;
            endcase
        end
    end

endmodule
